// File: rtl/cdr_phase_ctrl.sv
// CDR phase-select loop controller: integrates up/dn votes, steps the sampling phase, holds off, reports lock.
// Optional build macro CDR_PHASE_DECAY_EN makes the vote integrator leaky.
module cdr_phase_ctrl #(
    parameter int NPHASE      = 8,
    parameter int THRESH      = 8,
    parameter int CNT_W       = 5,
    parameter int HOLDOFF     = 3,
    parameter int LOCK_CYCLES = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      up,
    input  logic                      dn,
    output logic [$clog2(NPHASE)-1:0] phase_sel,
    output logic                      shift_strobe,
    output logic                      shift_dir,
    output logic                      lock,
    output logic [CNT_W-1:0]          acc_dbg
);

    localparam int PH_W    = $clog2(NPHASE);
    localparam int HOLD_W  = $clog2(HOLDOFF + 1);
    localparam int QUIET_W = $clog2(LOCK_CYCLES + 1);

    localparam logic signed [CNT_W-1:0]   ACC_MAX   = CNT_W'(THRESH - 1);
    localparam logic signed [CNT_W-1:0]   ACC_MIN   = CNT_W'(1 - THRESH);
    localparam logic signed [CNT_W-1:0]   ACC_ONE   = CNT_W'(1);
    localparam logic [HOLD_W-1:0]         HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [QUIET_W-1:0]        QUIET_MAX = QUIET_W'(LOCK_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_t;

    state_t                   state_q, state_d;
    logic signed [CNT_W-1:0]  acc_q, acc_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic [QUIET_W-1:0]       quiet_q, quiet_d;
    logic [PH_W-1:0]          phase_q, phase_d;
    logic                     dir_q, dir_d;
    logic                     strobe_q, strobe_d;
    logic                     lock_q, lock_d;
    logic                     vote_up, vote_dn;

`ifdef CDR_PHASE_DECAY_EN
    logic [3:0]               idle_q, idle_d;
`endif

    assign vote_up = up & ~dn;
    assign vote_dn = dn & ~up;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            hold_q   <= '0;
            quiet_q  <= '0;
            phase_q  <= '0;
            dir_q    <= 1'b0;
            strobe_q <= 1'b0;
            lock_q   <= 1'b0;
`ifdef CDR_PHASE_DECAY_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            hold_q   <= hold_d;
            quiet_q  <= quiet_d;
            phase_q  <= phase_d;
            dir_q    <= dir_d;
            strobe_q <= strobe_d;
            lock_q   <= lock_d;
`ifdef CDR_PHASE_DECAY_EN
            idle_q   <= idle_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        hold_d   = hold_q;
        quiet_d  = quiet_q;
        phase_d  = phase_q;
        dir_d    = dir_q;
        strobe_d = 1'b0;
`ifdef CDR_PHASE_DECAY_EN
        idle_d   = '0;
`endif

        // enable low wins over any step decision in the same cycle
        if (!enable) begin
            state_d = IDLE;
            acc_d   = '0;
            hold_d  = '0;
            quiet_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = TRACK;
                    acc_d   = '0;
                    hold_d  = '0;
                    quiet_d = '0;
                end
                TRACK: begin
                    if (vote_up && acc_q == ACC_MAX) begin
                        phase_d  = phase_q + PH_W'(1);
                        dir_d    = 1'b1;
                        strobe_d = 1'b1;
                        acc_d    = '0;
                        hold_d   = HOLD_LOAD;
                        quiet_d  = '0;
                        state_d  = HOLD;
                    end else if (vote_dn && acc_q == ACC_MIN) begin
                        phase_d  = phase_q - PH_W'(1);
                        dir_d    = 1'b0;
                        strobe_d = 1'b1;
                        acc_d    = '0;
                        hold_d   = HOLD_LOAD;
                        quiet_d  = '0;
                        state_d  = HOLD;
                    end else begin
                        if (vote_up) begin
                            acc_d = acc_q + ACC_ONE;
                        end else if (vote_dn) begin
                            acc_d = acc_q - ACC_ONE;
                        end
`ifdef CDR_PHASE_DECAY_EN
                        // 16th consecutive idle cycle pulls acc one step toward zero
                        if (!vote_up && !vote_dn) begin
                            if (idle_q == 4'd15) begin
                                idle_d = '0;
                                if (acc_q[CNT_W-1]) begin
                                    acc_d = acc_q + ACC_ONE;
                                end else if (acc_q != '0) begin
                                    acc_d = acc_q - ACC_ONE;
                                end
                            end else begin
                                idle_d = idle_q + 4'd1;
                            end
                        end
`endif
                        if (quiet_q != QUIET_MAX) begin
                            quiet_d = quiet_q + QUIET_W'(1);
                        end
                    end
                end
                HOLD: begin
                    acc_d  = '0;
                    hold_d = hold_q - HOLD_W'(1);
                    if (hold_q == HOLD_W'(1)) begin
                        state_d = TRACK;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    hold_d  = '0;
                    quiet_d = '0;
                end
            endcase
        end

        lock_d = (quiet_d == QUIET_MAX);
    end

    assign phase_sel    = phase_q;
    assign shift_strobe = strobe_q;
    assign shift_dir    = dir_q;
    assign lock         = lock_q;
    assign acc_dbg      = acc_q;

endmodule

// File: tb/tb_cdr_phase_ctrl.sv
// Directed bench for cdr_phase_ctrl with hand-computed expectations.
// Decay expectations follow CDR_PHASE_DECAY_EN when it is defined.
module tb_cdr_phase_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       up;
    logic       dn;
    logic [2:0] phase_sel;
    logic       shift_strobe;
    logic       shift_dir;
    logic       lock;
    logic [4:0] acc_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int strobes  = 0;
    int dbl      = 0;
    logic prev_strobe = 1'b0;

    cdr_phase_ctrl #(
        .NPHASE(8),
        .THRESH(8),
        .CNT_W(5),
        .HOLDOFF(3),
        .LOCK_CYCLES(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .up(up),
        .dn(dn),
        .phase_sel(phase_sel),
        .shift_strobe(shift_strobe),
        .shift_dir(shift_dir),
        .lock(lock),
        .acc_dbg(acc_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // apply votes for n cycles; outputs are stable 1 time unit after each edge
    task automatic run(input int n, input logic u, input logic d);
        for (int i = 0; i < n; i++) begin
            up = u;
            dn = d;
            @(posedge clk);
            #1;
            if (shift_strobe) begin
                strobes++;
                if (prev_strobe) dbl++;
            end
            prev_strobe = shift_strobe;
        end
    endtask

    function automatic int acc_s();
        return int'($signed(acc_dbg));
    endfunction

    initial begin
        rst = 1'b1; enable = 1'b0; up = 1'b0; dn = 1'b0;
        #2;
        check("rst_phase", int'(phase_sel), 0);
        check("rst_strobe", int'(shift_strobe), 0);
        check("rst_dir", int'(shift_dir), 0);
        check("rst_lock", int'(lock), 0);
        check("rst_acc", acc_s(), 0);
        #10 rst = 1'b0;

        // basic up integration and step, then HOLD timing
        enable = 1'b1;
        run(1, 1'b0, 1'b0);
        run(7, 1'b1, 1'b0);
        check("t1_acc7", acc_s(), 7);
        check("t1_phase0", int'(phase_sel), 0);
        run(1, 1'b1, 1'b0);
        check("t1_step_phase", int'(phase_sel), 1);
        check("t1_step_strobe", int'(shift_strobe), 1);
        check("t1_step_dir", int'(shift_dir), 1);
        check("t1_step_acc", acc_s(), 0);
        run(1, 1'b1, 1'b0);
        check("t1_strobe_off", int'(shift_strobe), 0);
        check("t1_hold_acc_a", acc_s(), 0);
        run(2, 1'b1, 1'b0);
        check("t1_hold_acc_b", acc_s(), 0);
        run(1, 1'b1, 1'b0);
        check("t1_first_vote", acc_s(), 1);

        // disable retains phase; down wrap and up wrap
        enable = 1'b0;
        run(1, 1'b1, 1'b0);
        check("t2_idle_phase", int'(phase_sel), 1);
        check("t2_idle_acc", acc_s(), 0);
        run(2, 1'b1, 1'b0);
        check("t2_idle_ignore", acc_s(), 0);
        enable = 1'b1;
        run(1, 1'b0, 1'b0);
        run(8, 1'b0, 1'b1);
        check("t2_dn_phase0", int'(phase_sel), 0);
        check("t2_dn_dir", int'(shift_dir), 0);
        run(3, 1'b0, 1'b0);
        run(7, 1'b0, 1'b1);
        check("t2_acc_m7", acc_s(), -7);
        run(1, 1'b0, 1'b1);
        check("t2_wrap_dn", int'(phase_sel), 7);
        check("t2_wrap_dir", int'(shift_dir), 0);
        run(3, 1'b0, 1'b0);
        run(8, 1'b1, 1'b0);
        check("t2_wrap_up", int'(phase_sel), 0);
        check("t2_wrap_updir", int'(shift_dir), 1);
        run(3, 1'b0, 1'b0);

        // continuous up for 40 cycles
        strobes = 0; dbl = 0;
        run(40, 1'b1, 1'b0);
        check("t3_strobes", strobes, 3);
        check("t3_phase", int'(phase_sel), 3);
        check("t3_no_dbl", dbl, 0);

        // alternating votes: no step, lock after 32 TRACK cycles
        enable = 1'b0;
        run(1, 1'b0, 1'b0);
        enable = 1'b1;
        run(1, 1'b0, 1'b0);
        strobes = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i % 2 == 1) run(1, 1'b1, 1'b0);
            else            run(1, 1'b0, 1'b1);
            if (i == 1)  check("t4_acc_1", acc_s(), 1);
            if (i == 2)  check("t4_acc_0", acc_s(), 0);
            if (i == 31) check("t4_lock_31", int'(lock), 0);
            if (i == 32) check("t4_lock_32", int'(lock), 1);
        end
        check("t4_lock_40", int'(lock), 1);
        check("t4_no_strobe", strobes, 0);
        run(7, 1'b1, 1'b0);
        check("t4_lock_pre", int'(lock), 1);
        run(1, 1'b1, 1'b0);
        check("t4_lock_drop", int'(lock), 0);
        check("t4_step_strobe", int'(shift_strobe), 1);
        check("t4_phase", int'(phase_sel), 4);
        run(3, 1'b0, 1'b0);

        // both votes high: nothing happens
        strobes = 0;
        run(20, 1'b1, 1'b1);
        check("t5_both_acc", acc_s(), 0);
        check("t5_both_strobe", strobes, 0);

        // disable mid-HOLD
        run(8, 1'b1, 1'b0);
        check("t5_step_phase", int'(phase_sel), 5);
        run(1, 1'b1, 1'b0);
        enable = 1'b0;
        run(1, 1'b1, 1'b0);
        check("t5_dis_phase", int'(phase_sel), 5);
        check("t5_dis_lock", int'(lock), 0);
        check("t5_dis_acc", acc_s(), 0);

        // async reset mid-TRACK with acc=5
        enable = 1'b1;
        run(1, 1'b0, 1'b0);
        run(5, 1'b1, 1'b0);
        check("t5_acc5", acc_s(), 5);
        up = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t5_rst_acc", acc_s(), 0);
        check("t5_rst_phase", int'(phase_sel), 0);
        check("t5_rst_strobe", int'(shift_strobe), 0);
        #2 rst = 1'b0;

        // decay behaviour (macro-dependent)
        run(1, 1'b0, 1'b0);
        run(3, 1'b1, 1'b0);
        check("t6_acc3", acc_s(), 3);
        for (int i = 1; i <= 48; i++) begin
            run(1, 1'b0, 1'b0);
`ifdef CDR_PHASE_DECAY_EN
            if (i == 15) check("t6_idle15", acc_s(), 3);
            if (i == 16) check("t6_idle16", acc_s(), 2);
            if (i == 32) check("t6_idle32", acc_s(), 1);
            if (i == 48) check("t6_idle48", acc_s(), 0);
`else
            if (i == 16) check("t6_idle16", acc_s(), 3);
            if (i == 48) check("t6_idle48", acc_s(), 3);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
